// File: rtl/mem_port_arb.sv
// Arbiter sharing one single-ported memory between instruction fetch (IF) and load/store (LS).
// LS has priority over IF; after MAX_WAIT consecutive LS wins while IF is waiting, IF is granted.
module mem_port_arb #(
  parameter int addr_width = 32,
  parameter int data_width = 32,
  parameter int MAX_WAIT   = 4
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  if_req_in,
  input  logic [addr_width-1:0] if_addr_in,
  output logic                  if_gnt_out,
  output logic                  if_valid_out,
  output logic [data_width-1:0] if_rdata_out,
  input  logic                  ls_req_in,
  input  logic                  ls_we_in,
  input  logic [addr_width-1:0] ls_addr_in,
  input  logic [data_width-1:0] ls_wdata_in,
  output logic                  ls_gnt_out,
  output logic                  ls_valid_out,
  output logic [data_width-1:0] ls_rdata_out,
  output logic                  mem_req_out,
  output logic                  mem_we_out,
  output logic [addr_width-1:0] mem_addr_out,
  output logic [data_width-1:0] mem_wdata_out,
  input  logic                  mem_ready_in,
  input  logic [data_width-1:0] mem_rdata_in,
  output logic                  sel_out
);

  localparam int CNT_W = $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_WAIT);

  typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_LS} state_t;

  state_t               state_q;
  logic [CNT_W-1:0]     starve_q;
  logic                 if_gnt_q, if_valid_q, ls_gnt_q, ls_valid_q;
  logic                 mem_req_q, mem_we_q, sel_q;
  logic [addr_width-1:0] mem_addr_q;
  logic [data_width-1:0] mem_wdata_q, if_rdata_q, ls_rdata_q;
  logic                 ls_win_d;

  // IF is starved only while it is actually requesting.
  assign ls_win_d = ls_req_in && !(if_req_in && (starve_q == CNT_MAX));

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q     <= IDLE;
      starve_q    <= '0;
      if_gnt_q    <= 1'b0;
      if_valid_q  <= 1'b0;
      ls_gnt_q    <= 1'b0;
      ls_valid_q  <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      sel_q       <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      ls_rdata_q  <= '0;
    end else begin
      if_gnt_q   <= 1'b0;
      ls_gnt_q   <= 1'b0;
      if_valid_q <= 1'b0;
      ls_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (ls_win_d) begin
            state_q     <= BUSY_LS;
            mem_req_q   <= 1'b1;
            mem_we_q    <= ls_we_in;
            mem_addr_q  <= ls_addr_in;
            mem_wdata_q <= ls_wdata_in;
            sel_q       <= 1'b1;
            ls_gnt_q    <= 1'b1;
            if (if_req_in && (starve_q != CNT_MAX)) starve_q <= starve_q + CNT_W'(1);
          end else if (if_req_in) begin
            state_q     <= BUSY_IF;
            mem_req_q   <= 1'b1;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= if_addr_in;
            mem_wdata_q <= '0;
            sel_q       <= 1'b0;
            if_gnt_q    <= 1'b1;
            starve_q    <= '0;
          end
        end
        BUSY_IF: begin
          if (mem_ready_in) begin
            state_q    <= IDLE;
            mem_req_q  <= 1'b0;
            mem_we_q   <= 1'b0;
            if_valid_q <= 1'b1;
            if_rdata_q <= mem_rdata_in;
          end
        end
        BUSY_LS: begin
          if (mem_ready_in) begin
            state_q    <= IDLE;
            mem_req_q  <= 1'b0;
            mem_we_q   <= 1'b0;
            ls_valid_q <= 1'b1;
            if (!mem_we_q) ls_rdata_q <= mem_rdata_in;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign if_gnt_out    = if_gnt_q;
  assign if_valid_out  = if_valid_q;
  assign if_rdata_out  = if_rdata_q;
  assign ls_gnt_out    = ls_gnt_q;
  assign ls_valid_out  = ls_valid_q;
  assign ls_rdata_out  = ls_rdata_q;
  assign mem_req_out   = mem_req_q;
  assign mem_we_out    = mem_we_q;
  assign mem_addr_out  = mem_addr_q;
  assign mem_wdata_out = mem_wdata_q;
  assign sel_out       = sel_q;

endmodule

// File: tb/tb_mem_port_arb.sv
// Bench for mem_port_arb: directed scenarios followed by randomized traffic,
// checked against a transaction-level model of the arbitration rules.
module tb_mem_port_arb;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int MW = 4;

  logic          clk_in = 1'b0;
  logic          rst_in;
  logic          if_req_in, ls_req_in, ls_we_in, mem_ready_in;
  logic [AW-1:0] if_addr_in, ls_addr_in;
  logic [DW-1:0] ls_wdata_in, mem_rdata_in;
  logic          if_gnt_out, if_valid_out, ls_gnt_out, ls_valid_out;
  logic          mem_req_out, mem_we_out, sel_out;
  logic [DW-1:0] if_rdata_out, ls_rdata_out, mem_wdata_out;
  logic [AW-1:0] mem_addr_out;

  mem_port_arb #(.addr_width(AW), .data_width(DW), .MAX_WAIT(MW)) dut (
    .clk_in(clk_in), .rst_in(rst_in),
    .if_req_in(if_req_in), .if_addr_in(if_addr_in),
    .if_gnt_out(if_gnt_out), .if_valid_out(if_valid_out), .if_rdata_out(if_rdata_out),
    .ls_req_in(ls_req_in), .ls_we_in(ls_we_in), .ls_addr_in(ls_addr_in),
    .ls_wdata_in(ls_wdata_in), .ls_gnt_out(ls_gnt_out), .ls_valid_out(ls_valid_out),
    .ls_rdata_out(ls_rdata_out), .mem_req_out(mem_req_out), .mem_we_out(mem_we_out),
    .mem_addr_out(mem_addr_out), .mem_wdata_out(mem_wdata_out),
    .mem_ready_in(mem_ready_in), .mem_rdata_in(mem_rdata_in), .sel_out(sel_out)
  );

  always #5 clk_in = ~clk_in;

  int      tests = 0;
  int      fails = 0;
  int      starve_m = 0;
  logic    sel_m = 1'b0;
  logic [DW-1:0] if_rd_m = '0;
  logic [DW-1:0] ls_rd_m = '0;
  logic    won;

  task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk(tag, {if_gnt_out, if_valid_out, if_rdata_out, ls_gnt_out, ls_valid_out, ls_rdata_out,
              mem_req_out, mem_we_out, mem_addr_out, mem_wdata_out, sel_out}, '0);
  endtask

  // One full transaction: grant at the next edge, ready after k cycles.
  task automatic run_txn(input int k, input logic [DW-1:0] rd, input bit keep, output logic won_ls);
    logic          ls_w, ewe;
    logic [AW-1:0] ea;
    logic [DW-1:0] ewd;
    ls_w = ls_req_in && !(if_req_in && starve_m == MW);
    if (ls_w) begin
      if (if_req_in && starve_m < MW) starve_m++;
      ea = ls_addr_in; ewe = ls_we_in; ewd = ls_wdata_in;
    end else begin
      starve_m = 0;
      ea = if_addr_in; ewe = 1'b0; ewd = '0;
    end
    sel_m = ls_w;
    tick();
    won_ls = sel_out;
    chk("gnt", {if_gnt_out, ls_gnt_out}, {!ls_w, ls_w});
    chk("sel", sel_out, sel_m);
    chk("mem_req", mem_req_out, 1);
    chk("mem_addr", mem_addr_out, ea);
    chk("mem_we", mem_we_out, ewe);
    chk("mem_wdata", mem_wdata_out, ewd);
    if (!keep) begin
      if (ls_w) ls_req_in = 1'b0;
      else if_req_in = 1'b0;
    end
    for (int j = 1; j < k; j++) begin
      tick();
      chk("hold", {mem_req_out, mem_we_out, mem_addr_out, mem_wdata_out,
                   if_gnt_out, ls_gnt_out, if_valid_out, ls_valid_out},
                  {1'b1, ewe, ea, ewd, 4'b0});
    end
    mem_ready_in = 1'b1;
    mem_rdata_in = rd;
    tick();
    mem_ready_in = 1'b0;
    mem_rdata_in = $urandom;
    if (!ewe) begin
      if (ls_w) ls_rd_m = rd;
      else if_rd_m = rd;
    end
    chk("done", {if_valid_out, ls_valid_out, if_gnt_out, ls_gnt_out, mem_req_out, mem_we_out},
                {!ls_w, ls_w, 4'b0});
    chk("if_rdata", if_rdata_out, if_rd_m);
    chk("ls_rdata", ls_rdata_out, ls_rd_m);
    chk("sel_hold", sel_out, sel_m);
  endtask

  initial begin
    rst_in = 1'b1;
    if_req_in = 1'b0; ls_req_in = 1'b0; ls_we_in = 1'b0; mem_ready_in = 1'b0;
    if_addr_in = '0; ls_addr_in = '0; ls_wdata_in = '0; mem_rdata_in = '0;
    repeat (2) @(posedge clk_in);
    #1;
    chk_all_zero("reset_state");
    rst_in = 1'b0;
    tick();
    chk_all_zero("post_reset_idle");

    // Reset asserted in the middle of an LS transaction.
    ls_req_in = 1'b1; ls_we_in = 1'b0; ls_addr_in = 32'h300;
    tick();
    chk("t1_gnt", {ls_gnt_out, mem_req_out, sel_out}, 3'b111);
    ls_req_in = 1'b0;
    tick();
    #2 rst_in = 1'b1;
    #1 chk_all_zero("t1_async_rst");
    rst_in = 1'b0;
    mem_ready_in = 1'b1;
    tick();
    mem_ready_in = 1'b0;
    chk_all_zero("t1_after_rst_a");
    tick();
    chk_all_zero("t1_after_rst_b");

    // IF read, ready two cycles after the grant.
    if_req_in = 1'b1; if_addr_in = 32'h100;
    run_txn(2, 32'hDEADBEEF, 1'b0, won);
    chk("t2_if_rdata", if_rdata_out, 32'hDEADBEEF);

    // Simultaneous requests: LS wins, then IF after one idle cycle.
    if_req_in = 1'b1; if_addr_in = 32'h104;
    ls_req_in = 1'b1; ls_we_in = 1'b0; ls_addr_in = 32'h2000;
    run_txn(1, 32'hCAFE0001, 1'b0, won);
    chk("t3_first_ls", won, 1);
    run_txn(2, 32'h0BADF00D, 1'b0, won);
    chk("t3_second_if", won, 0);

    // Store leaves ls_rdata unchanged.
    ls_req_in = 1'b1; ls_we_in = 1'b1; ls_addr_in = 32'h200; ls_wdata_in = 32'h12345678;
    run_txn(1, 32'h55555555, 1'b0, won);
    chk("t4_ls_rdata_kept", ls_rdata_out, 32'hCAFE0001);

    // Starvation: both held, expected LS x4 then IF then LS.
    begin
      logic [5:0] pattern;
      pattern = 6'b111101;
      if_req_in = 1'b1; if_addr_in = 32'h400;
      ls_req_in = 1'b1; ls_we_in = 1'b0; ls_addr_in = 32'h800;
      for (int i = 0; i < 6; i++) begin
        run_txn(1, $urandom, 1'b1, won);
        chk($sformatf("t5_order_%0d", i), won, pattern[5-i]);
      end
      if_req_in = 1'b0; ls_req_in = 1'b0;
    end

    // Ready pulse while idle is ignored.
    mem_ready_in = 1'b1; mem_rdata_in = 32'hFFFF0000;
    tick();
    mem_ready_in = 1'b0;
    chk("t6_idle_ready", {if_valid_out, ls_valid_out, if_gnt_out, ls_gnt_out, mem_req_out,
                          if_rdata_out, ls_rdata_out, sel_out},
                         {5'b0, if_rd_m, ls_rd_m, sel_m});
    tick();
    chk("t6_idle_ready_b", {if_valid_out, ls_valid_out, mem_req_out}, 3'b0);

    // Randomized traffic.
    for (int r = 0; r < 60; r++) begin
      if (!if_req_in && $urandom_range(0, 1) != 0) begin
        if_req_in = 1'b1; if_addr_in = $urandom;
      end
      if (!ls_req_in && $urandom_range(0, 2) != 0) begin
        ls_req_in = 1'b1; ls_we_in = 1'($urandom_range(0, 1));
        ls_addr_in = $urandom; ls_wdata_in = $urandom;
      end
      if (!if_req_in && !ls_req_in) begin
        mem_ready_in = 1'($urandom_range(0, 1));
        tick();
        mem_ready_in = 1'b0;
        chk("rnd_idle", {if_valid_out, ls_valid_out, if_gnt_out, ls_gnt_out, mem_req_out, sel_out},
                        {5'b0, sel_m});
      end else begin
        run_txn($urandom_range(1, 4), $urandom, ($urandom_range(0, 3) == 0), won);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
